// File: rtl/cs_address_sequencer_if.sv
// Microinstruction-side bus of the control-store address sequencer.
// The sequencer is the slave; whoever presents the microinstruction fields is the master.
interface cs_address_sequencer_if #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_DECODEROP   = 8
);
  logic [DATAWIDTH_CONDITION-1:0]   CS_ADDRESS_SEQUENCER_Condition_InBus;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
  logic [DATAWIDTH_DECODEROP-1:0]   CS_ADDRESS_SEQUENCER_DecodeOp_InBus;
  logic                             CS_ADDRESS_SEQUENCER_IR13_In;
  logic [3:0]                       CS_ADDRESS_SEQUENCER_Flags_InBus;
  logic                             CS_ADDRESS_SEQUENCER_FlagsLoad_In;
  logic                             CS_ADDRESS_SEQUENCER_MemRequest_In;
  logic                             CS_ADDRESS_SEQUENCER_MemReady_In;
  logic [DATAWIDTH_JUMPADDRESS-1:0] CS_ADDRESS_SEQUENCER_CSAddress_OutBus;
  logic [3:0]                       CS_ADDRESS_SEQUENCER_PSR_OutBus;
  logic                             CS_ADDRESS_SEQUENCER_Stall_Out;

  modport master (
    output CS_ADDRESS_SEQUENCER_Condition_InBus, CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
           CS_ADDRESS_SEQUENCER_DecodeOp_InBus, CS_ADDRESS_SEQUENCER_IR13_In,
           CS_ADDRESS_SEQUENCER_Flags_InBus, CS_ADDRESS_SEQUENCER_FlagsLoad_In,
           CS_ADDRESS_SEQUENCER_MemRequest_In, CS_ADDRESS_SEQUENCER_MemReady_In,
    input  CS_ADDRESS_SEQUENCER_CSAddress_OutBus, CS_ADDRESS_SEQUENCER_PSR_OutBus,
           CS_ADDRESS_SEQUENCER_Stall_Out
  );

  modport slave (
    input  CS_ADDRESS_SEQUENCER_Condition_InBus, CS_ADDRESS_SEQUENCER_JumpAddress_InBus,
           CS_ADDRESS_SEQUENCER_DecodeOp_InBus, CS_ADDRESS_SEQUENCER_IR13_In,
           CS_ADDRESS_SEQUENCER_Flags_InBus, CS_ADDRESS_SEQUENCER_FlagsLoad_In,
           CS_ADDRESS_SEQUENCER_MemRequest_In, CS_ADDRESS_SEQUENCER_MemReady_In,
    output CS_ADDRESS_SEQUENCER_CSAddress_OutBus, CS_ADDRESS_SEQUENCER_PSR_OutBus,
           CS_ADDRESS_SEQUENCER_Stall_Out
  );
endinterface

// File: rtl/cs_address_sequencer.sv
// Microprogram sequencer: holds MicroPC and PSR, picks the next control-store address
// from increment, conditional/unconditional jump or opcode decode, and freezes on memory waits.
module cs_address_sequencer #(
  parameter int DATAWIDTH_JUMPADDRESS = 11,
  parameter int DATAWIDTH_CONDITION   = 3,
  parameter int DATAWIDTH_DECODEROP   = 8
) (
  input  logic CS_ADDRESS_SEQUENCER_CLOCK_50,
  input  logic CS_ADDRESS_SEQUENCER_ResetInLow_In,
  cs_address_sequencer_if.slave seqBus
);
  logic [DATAWIDTH_JUMPADDRESS-1:0] microPc;
  logic [DATAWIDTH_JUMPADDRESS-1:0] csai;
  logic [DATAWIDTH_JUMPADDRESS-1:0] decodeAddr;
  logic [DATAWIDTH_JUMPADDRESS-1:0] nextAddr;
  logic [3:0]                       psr;
  logic                             takeJump;
  logic                             stall;

  assign stall = seqBus.CS_ADDRESS_SEQUENCER_MemRequest_In & ~seqBus.CS_ADDRESS_SEQUENCER_MemReady_In;
  assign csai  = microPc + {{(DATAWIDTH_JUMPADDRESS-1){1'b0}}, 1'b1};
  // Decode targets are 4-word slots in the upper half of the store.
  assign decodeAddr = DATAWIDTH_JUMPADDRESS'({1'b1, seqBus.CS_ADDRESS_SEQUENCER_DecodeOp_InBus, 2'b00});

  always_comb begin
    takeJump = 1'b0;
    nextAddr = csai;
    case (seqBus.CS_ADDRESS_SEQUENCER_Condition_InBus)
      DATAWIDTH_CONDITION'(1): takeJump = psr[3];
      DATAWIDTH_CONDITION'(2): takeJump = psr[2];
      DATAWIDTH_CONDITION'(3): takeJump = psr[1];
      DATAWIDTH_CONDITION'(4): takeJump = psr[0];
      DATAWIDTH_CONDITION'(5): takeJump = seqBus.CS_ADDRESS_SEQUENCER_IR13_In;
      DATAWIDTH_CONDITION'(6): takeJump = 1'b1;
      default:                 takeJump = 1'b0;
    endcase
    if (seqBus.CS_ADDRESS_SEQUENCER_Condition_InBus == DATAWIDTH_CONDITION'(7)) begin
      nextAddr = decodeAddr;
    end else if (takeJump) begin
      nextAddr = seqBus.CS_ADDRESS_SEQUENCER_JumpAddress_InBus;
    end
  end

  // Branches use the PSR as it stood before this edge; a same-cycle flag load is seen next cycle.
  always_ff @(posedge CS_ADDRESS_SEQUENCER_CLOCK_50 or negedge CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
    if (!CS_ADDRESS_SEQUENCER_ResetInLow_In) begin
      microPc <= '0;
      psr     <= '0;
    end else if (!stall) begin
      microPc <= nextAddr;
      if (seqBus.CS_ADDRESS_SEQUENCER_FlagsLoad_In) begin
        psr <= seqBus.CS_ADDRESS_SEQUENCER_Flags_InBus;
      end
    end
  end

  assign seqBus.CS_ADDRESS_SEQUENCER_CSAddress_OutBus = microPc;
  assign seqBus.CS_ADDRESS_SEQUENCER_PSR_OutBus       = psr;
  assign seqBus.CS_ADDRESS_SEQUENCER_Stall_Out        = stall;
endmodule
